// File: rtl/regfile_scoreboard.sv
// Integer register file: two write ports, two read ports, same-cycle bypass and a busy scoreboard.
// Index 0 is hardwired to zero and carries no busy state.
module regfile_scoreboard #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  WEN0,
  input  logic [ADDR_WIDTH-1:0] RD0_SEL,
  input  logic [DATA_WIDTH-1:0] WB0_DATA,
  input  logic                  WEN1,
  input  logic [ADDR_WIDTH-1:0] RD1_SEL,
  input  logic [DATA_WIDTH-1:0] WB1_DATA,
  input  logic                  ISSUE_VALID,
  input  logic [ADDR_WIDTH-1:0] ISSUE_RD_SEL,
  input  logic [ADDR_WIDTH-1:0] RS1_SEL,
  input  logic [ADDR_WIDTH-1:0] RS2_SEL,
  output logic [DATA_WIDTH-1:0] SRC1_DOUT,
  output logic [DATA_WIDTH-1:0] SRC2_DOUT,
  output logic                  SRC1_BUSY,
  output logic                  SRC2_BUSY,
  output logic                  WR_CONFLICT
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;
  localparam int unsigned NUM_RD   = 2;
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = '0;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_d;
  logic                  wr_conflict_q;
  logic                  wr_conflict_d;

  logic wr0_en;
  logic wr1_clr;
  logic wr1_en;
  logic same_dst;
  logic issue_en;

  // Qualify write/issue requests; index 0 is never a real destination.
  always_comb begin
    wr0_en   = WEN0 && (RD0_SEL != ZERO_IDX);
    wr1_clr  = WEN1 && (RD1_SEL != ZERO_IDX);
    same_dst = (RD0_SEL == RD1_SEL);
    // Port 0 wins a same-index collision, so port 1 data is dropped.
    wr1_en   = wr1_clr && !(wr0_en && same_dst);
    issue_en = ISSUE_VALID && (ISSUE_RD_SEL != ZERO_IDX);
  end

  // Next register contents: reset clears everything, otherwise apply both write ports.
  always_comb begin
    regs_d = regs_q;
    if (RESET) begin
      regs_d = '{default: '0};
    end else begin
      if (wr1_en) begin
        regs_d[RD1_SEL] = WB1_DATA;
      end
      if (wr0_en) begin
        regs_d[RD0_SEL] = WB0_DATA;
      end
    end
  end

  // Next scoreboard state: late writeback clears, issue sets, and set wins a tie.
  always_comb begin
    busy_d        = busy_q;
    wr_conflict_d = 1'b0;
    if (RESET) begin
      busy_d = '0;
    end else begin
      if (wr1_clr) begin
        busy_d[RD1_SEL] = 1'b0;
      end
      if (issue_en) begin
        busy_d[ISSUE_RD_SEL] = 1'b1;
      end
      wr_conflict_d = wr0_en && WEN1 && same_dst;
    end
    busy_d[0] = 1'b0;
  end

  // State registers; reset is folded into the next-state logic.
  always_ff @(posedge CLK) begin
    regs_q        <= regs_d;
    busy_q        <= busy_d;
    wr_conflict_q <= wr_conflict_d;
  end

  assign WR_CONFLICT = wr_conflict_q;

  logic [ADDR_WIDTH-1:0] rs_sel   [NUM_RD];
  logic [DATA_WIDTH-1:0] src_dout [NUM_RD];
  logic                  src_busy [NUM_RD];

  assign rs_sel[0] = RS1_SEL;
  assign rs_sel[1] = RS2_SEL;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_read
    logic hit0;
    logic hit1;
    logic set_hit;

    // Read mux: stored value, optionally overridden by same-cycle write data and busy clear.
    always_comb begin
      hit0        = WEN0 && (RD0_SEL == rs_sel[p]);
      hit1        = WEN1 && (RD1_SEL == rs_sel[p]);
      set_hit     = ISSUE_VALID && (ISSUE_RD_SEL == rs_sel[p]);
      src_dout[p] = regs_q[rs_sel[p]];
      src_busy[p] = busy_q[rs_sel[p]];
      if (BYPASS != 0) begin
        if (hit0) begin
          src_dout[p] = WB0_DATA;
        end else if (hit1) begin
          src_dout[p] = WB1_DATA;
        end
        // A same-cycle re-issue keeps the register owned by the newer op.
        if (hit1 && !set_hit) begin
          src_busy[p] = 1'b0;
        end
      end
      if (rs_sel[p] == ZERO_IDX) begin
        src_dout[p] = '0;
        src_busy[p] = 1'b0;
      end
    end
  end

  assign SRC1_DOUT = src_dout[0];
  assign SRC2_DOUT = src_dout[1];
  assign SRC1_BUSY = src_busy[0];
  assign SRC2_BUSY = src_busy[1];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: bypass and stored-only builds plus a 64-bit/16-entry build.
module tb_regfile_scoreboard;

  logic        clk;
  logic        reset;
  logic        wen0;
  logic [4:0]  rd0_sel;
  logic [31:0] wb0_data;
  logic        wen1;
  logic [4:0]  rd1_sel;
  logic [31:0] wb1_data;
  logic        issue_valid;
  logic [4:0]  issue_rd_sel;
  logic [4:0]  rs1_sel;
  logic [4:0]  rs2_sel;

  logic [31:0] a_dout1, a_dout2, b_dout1, b_dout2;
  logic        a_busy1, a_busy2, b_busy1, b_busy2;
  logic        a_conf, b_conf;

  logic        w_wen0, w_wen1, w_issue;
  logic [3:0]  w_rd0, w_rd1, w_issue_rd, w_rs1, w_rs2;
  logic [63:0] w_wb0, w_wb1;
  logic [63:0] w_dout1, w_dout2;
  logic        w_busy1, w_busy2, w_conf;

  int n_checks;
  int n_fail;

  regfile_scoreboard #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .BYPASS(1)) u_byp (
    .CLK(clk), .RESET(reset),
    .WEN0(wen0), .RD0_SEL(rd0_sel), .WB0_DATA(wb0_data),
    .WEN1(wen1), .RD1_SEL(rd1_sel), .WB1_DATA(wb1_data),
    .ISSUE_VALID(issue_valid), .ISSUE_RD_SEL(issue_rd_sel),
    .RS1_SEL(rs1_sel), .RS2_SEL(rs2_sel),
    .SRC1_DOUT(a_dout1), .SRC2_DOUT(a_dout2),
    .SRC1_BUSY(a_busy1), .SRC2_BUSY(a_busy2),
    .WR_CONFLICT(a_conf)
  );

  regfile_scoreboard #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .BYPASS(0)) u_nobyp (
    .CLK(clk), .RESET(reset),
    .WEN0(wen0), .RD0_SEL(rd0_sel), .WB0_DATA(wb0_data),
    .WEN1(wen1), .RD1_SEL(rd1_sel), .WB1_DATA(wb1_data),
    .ISSUE_VALID(issue_valid), .ISSUE_RD_SEL(issue_rd_sel),
    .RS1_SEL(rs1_sel), .RS2_SEL(rs2_sel),
    .SRC1_DOUT(b_dout1), .SRC2_DOUT(b_dout2),
    .SRC1_BUSY(b_busy1), .SRC2_BUSY(b_busy2),
    .WR_CONFLICT(b_conf)
  );

  regfile_scoreboard #(.ADDR_WIDTH(4), .DATA_WIDTH(64), .BYPASS(1)) u_wide (
    .CLK(clk), .RESET(reset),
    .WEN0(w_wen0), .RD0_SEL(w_rd0), .WB0_DATA(w_wb0),
    .WEN1(w_wen1), .RD1_SEL(w_rd1), .WB1_DATA(w_wb1),
    .ISSUE_VALID(w_issue), .ISSUE_RD_SEL(w_issue_rd),
    .RS1_SEL(w_rs1), .RS2_SEL(w_rs2),
    .SRC1_DOUT(w_dout1), .SRC2_DOUT(w_dout2),
    .SRC1_BUSY(w_busy1), .SRC2_BUSY(w_busy2),
    .WR_CONFLICT(w_conf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge and let registered outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wen0 = 1'b0; wen1 = 1'b0; issue_valid = 1'b0;
    w_wen0 = 1'b0; w_wen1 = 1'b0; w_issue = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1;
    idle();
    rd0_sel = '0; rd1_sel = '0; issue_rd_sel = '0; wb0_data = '0; wb1_data = '0;
    rs1_sel = '0; rs2_sel = '0;
    w_rd0 = '0; w_rd1 = '0; w_issue_rd = '0; w_wb0 = '0; w_wb1 = '0; w_rs1 = '0; w_rs2 = '0;
    tick();
    tick();
    reset = 1'b0;
    #1;

    // Post-reset state
    check("rst_conf", 64'(a_conf), 64'd0);
    for (int r = 1; r < 32; r++) begin
      rs1_sel = 5'(r);
      rs2_sel = 5'(r);
      #1;
      check($sformatf("rst_d1_r%0d", r), 64'(a_dout1), 64'd0);
      check($sformatf("rst_d2_r%0d", r), 64'(a_dout2), 64'd0);
      check($sformatf("rst_b1_r%0d", r), 64'(a_busy1), 64'd0);
      check($sformatf("rst_b2_r%0d", r), 64'(a_busy2), 64'd0);
    end

    // Reset dominates a write in the same cycle
    reset = 1'b1; wen0 = 1'b1; rd0_sel = 5'd5; wb0_data = 32'h1234_5678;
    tick();
    reset = 1'b0; idle(); rs1_sel = 5'd5;
    #1;
    check("rst_wr_byp", 64'(a_dout1), 64'd0);
    check("rst_wr_nobyp", 64'(b_dout1), 64'd0);

    // Same-cycle bypass vs stored-only read
    wen0 = 1'b1; rd0_sel = 5'd3; wb0_data = 32'hDEAD_BEEF; rs1_sel = 5'd3;
    #1;
    check("byp_same_cyc", 64'(a_dout1), 64'hDEAD_BEEF);
    check("nobyp_same_cyc", 64'(b_dout1), 64'd0);
    tick();
    idle();
    #1;
    check("nobyp_next_cyc", 64'(b_dout1), 64'hDEAD_BEEF);
    check("byp_next_cyc", 64'(a_dout1), 64'hDEAD_BEEF);

    // Dual write to the same index: port 0 wins, one-cycle conflict pulse
    wen0 = 1'b1; rd0_sel = 5'd7; wb0_data = 32'h11;
    wen1 = 1'b1; rd1_sel = 5'd7; wb1_data = 32'h22;
    rs1_sel = 5'd7;
    #1;
    check("conf_byp_prio", 64'(a_dout1), 64'h11);
    tick();
    idle();
    #1;
    check("conf_r7", 64'(a_dout1), 64'h11);
    check("conf_r7_nobyp", 64'(b_dout1), 64'h11);
    check("conf_pulse", 64'(a_conf), 64'd1);
    check("conf_pulse_nobyp", 64'(b_conf), 64'd1);
    tick();
    check("conf_drop", 64'(a_conf), 64'd0);

    // Same stimulus on r0: ignored, no conflict
    wen0 = 1'b1; rd0_sel = 5'd0; wb0_data = 32'h11;
    wen1 = 1'b1; rd1_sel = 5'd0; wb1_data = 32'h22;
    rs1_sel = 5'd0;
    #1;
    check("r0_byp", 64'(a_dout1), 64'd0);
    tick();
    idle();
    #1;
    check("r0_stored", 64'(a_dout1), 64'd0);
    check("r0_conf", 64'(a_conf), 64'd0);

    // Dual write to distinct indices: both land, no conflict
    wen0 = 1'b1; rd0_sel = 5'd10; wb0_data = 32'h0A;
    wen1 = 1'b1; rd1_sel = 5'd11; wb1_data = 32'h0B;
    tick();
    idle(); rs1_sel = 5'd10; rs2_sel = 5'd11;
    #1;
    check("dual_r10", 64'(a_dout1), 64'h0A);
    check("dual_r11", 64'(a_dout2), 64'h0B);
    check("dual_conf", 64'(a_conf), 64'd0);

    // Issue sets busy only from the next cycle
    issue_valid = 1'b1; issue_rd_sel = 5'd9; rs2_sel = 5'd9;
    #1;
    check("issue_no_fwd", 64'(a_busy2), 64'd0);
    tick();
    idle();
    #1;
    check("issue_busy_byp", 64'(a_busy2), 64'd1);
    check("issue_busy_nobyp", 64'(b_busy2), 64'd1);

    // Late writeback clears busy, forwarded only in the bypass build
    wen1 = 1'b1; rd1_sel = 5'd9; wb1_data = 32'h55;
    #1;
    check("clr_busy_byp", 64'(a_busy2), 64'd0);
    check("clr_data_byp", 64'(a_dout2), 64'h55);
    check("clr_busy_nobyp", 64'(b_busy2), 64'd1);
    check("clr_data_nobyp", 64'(b_dout2), 64'd0);
    tick();
    idle();
    #1;
    check("clr_after_byp", 64'(a_busy2), 64'd0);
    check("clr_after_nobyp", 64'(b_busy2), 64'd0);
    check("clr_data_after", 64'(b_dout2), 64'h55);

    // Set and clear of a busy register in the same cycle: set wins
    issue_valid = 1'b1; issue_rd_sel = 5'd4; rs1_sel = 5'd4;
    tick();
    wen1 = 1'b1; rd1_sel = 5'd4; wb1_data = 32'h44;
    #1;
    check("setclr_same_cyc", 64'(a_busy1), 64'd1);
    tick();
    idle();
    #1;
    check("setclr_busy", 64'(a_busy1), 64'd1);
    check("setclr_data", 64'(a_dout1), 64'h44);

    // Two issues were outstanding; a single clear releases the register
    wen1 = 1'b1; rd1_sel = 5'd4; wb1_data = 32'h45;
    tick();
    idle();
    #1;
    check("one_clr_busy", 64'(a_busy1), 64'd0);
    check("one_clr_data", 64'(a_dout1), 64'h45);

    // WEN0 leaves busy untouched
    issue_valid = 1'b1; issue_rd_sel = 5'd12; rs1_sel = 5'd12;
    tick();
    idle(); wen0 = 1'b1; rd0_sel = 5'd12; wb0_data = 32'h12;
    tick();
    idle();
    #1;
    check("wen0_keeps_busy", 64'(a_busy1), 64'd1);

    // Issue to r0 is ignored
    issue_valid = 1'b1; issue_rd_sel = 5'd0; rs1_sel = 5'd0;
    tick();
    idle();
    #1;
    check("issue_r0", 64'(a_busy1), 64'd0);

    // Wide build: 64-bit data held intact in the top entry of a 16-entry file
    w_wen0 = 1'b1; w_rd0 = 4'd15; w_wb0 = 64'hFFFF_0000_1234_5678;
    w_wen1 = 1'b1; w_rd1 = 4'd1;  w_wb1 = 64'h8000_0000_0000_0001;
    tick();
    idle(); w_rs1 = 4'd15; w_rs2 = 4'd1;
    #1;
    check("wide_r15", w_dout1, 64'hFFFF_0000_1234_5678);
    check("wide_r1", w_dout2, 64'h8000_0000_0000_0001);
    w_rs1 = 4'd15 + 4'd1;
    #1;
    check("wide_wrap_r0", w_dout1, 64'd0);
    check("wide_conf", 64'(w_conf), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
